// File: rtl/ic_pkg.sv
// Shared widths and FSM encoding for the instruction-cache fill path.
package ic_pkg;
    localparam int IC_LINE_W = 256;
    localparam int IC_BEAT_W = 64;
    localparam int IC_BEATS  = 4;
    localparam int IC_ADDR_W = 15;
    localparam int IC_OFF_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_ACK  = 2'd3
    } ic_state_e;
endpackage

// File: rtl/ic_line_buf.sv
// Line assembly buffer: one register per beat slot, presented as a flat line.
module ic_line_buf #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    parameter int SEL_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         slot,
    input  logic [BEAT_W-1:0]        wdata,
    output logic [BEATS*BEAT_W-1:0]  line
);
    logic [BEAT_W-1:0] bank [BEATS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BEATS; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[slot] <= wdata;
        end
    end

    always_comb begin
        line = '0;
        for (int i = 0; i < BEATS; i++) begin
            line[i*BEAT_W +: BEAT_W] = bank[i];
        end
    end
endmodule

// File: rtl/ic_fill_ctrl.sv
// I-cache miss/fill controller: one outstanding line fetch, assembled from
// bus beats and handed to the cache with a single-cycle ack.
//
//   state | meaning
//   IDLE  | waiting for a miss (ignored for one cycle after an ack)
//   REQ   | bus read request asserted, waiting for grant
//   DATA  | collecting beats; drop flag marks a flushed fill
//   ACK   | line presented to the cache for one cycle
module ic_fill_ctrl
    import ic_pkg::*;
#(
    parameter int BEATS  = IC_BEATS,
    parameter int BEAT_W = IC_BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ic_miss,
    input  logic [IC_ADDR_W-1:0]     ic_miss_addr,
    input  logic                     fetch_flush,
    output logic                     mem_req,
    output logic [IC_ADDR_W-1:0]     mem_addr,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [BEAT_W-1:0]        mem_rdata,
    output logic [BEATS*BEAT_W-1:0]  ic_fill_data,
    output logic                     ic_miss_ack,
    output logic                     busy
);
    localparam int SEL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [SEL_W-1:0]     LAST_BEAT = SEL_W'(BEATS - 1);
    localparam logic [IC_ADDR_W-1:0] OFF_MASK  = IC_ADDR_W'((1 << IC_OFF_W) - 1);

    ic_state_e              state, state_nxt;
    logic [IC_ADDR_W-1:0]   addr_q, addr_nxt;
    logic [SEL_W-1:0]       beat_cnt, beat_cnt_nxt;
    logic                   drop_q, drop_nxt;
    logic                   done_q, done_nxt;
    logic                   buf_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            beat_cnt <= '0;
            drop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            beat_cnt <= beat_cnt_nxt;
            drop_q   <= drop_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        beat_cnt_nxt = beat_cnt;
        drop_nxt     = drop_q;
        done_nxt     = done_q;
        buf_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                done_nxt = 1'b0;
                if (!done_q && ic_miss && !fetch_flush) begin
                    addr_nxt  = ic_miss_addr & ~OFF_MASK;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // A grant commits the bus read, so it wins over a same-cycle flush.
                if (mem_gnt) begin
                    beat_cnt_nxt = '0;
                    drop_nxt     = fetch_flush;
                    state_nxt    = ST_DATA;
                end else if (fetch_flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fetch_flush) begin
                    drop_nxt = 1'b1;
                end
                if (mem_rvalid) begin
                    buf_we       = 1'b1;
                    beat_cnt_nxt = beat_cnt + SEL_W'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        drop_nxt  = 1'b0;
                        // A flush on the final beat still abandons the fill.
                        state_nxt = (drop_q || fetch_flush) ? ST_IDLE : ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_req     = (state == ST_REQ);
    assign mem_addr    = addr_q;
    assign ic_miss_ack = (state == ST_ACK);
    assign busy        = (state != ST_IDLE);

    ic_line_buf #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W),
        .SEL_W  (SEL_W)
    ) u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .wr_en (buf_we),
        .slot  (beat_cnt),
        .wdata (mem_rdata),
        .line  (ic_fill_data)
    );
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Bench for ic_fill_ctrl: directed scenarios plus random traffic against a
// transaction-level reference model checked every cycle.
module tb_ic_fill_ctrl;
    logic          clk = 1'b0;
    logic          rst, ic_miss, fetch_flush, mem_gnt, mem_rvalid;
    logic [14:0]   ic_miss_addr, mem_addr;
    logic [63:0]   mem_rdata;
    logic [255:0]  ic_fill_data;
    logic          mem_req, ic_miss_ack, busy;

    always #5 clk = ~clk;

    ic_fill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ic_miss      (ic_miss),
        .ic_miss_addr (ic_miss_addr),
        .fetch_flush  (fetch_flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ic_fill_data (ic_fill_data),
        .ic_miss_ack  (ic_miss_ack),
        .busy         (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a pending request, a burst with beats received so far,
    // an abandon mark, a post-ack lockout, and the line contents.
    bit          m_req, m_ack, m_busy, m_burst, m_abandon, m_lock;
    int          m_got;
    logic [14:0] m_addr;
    logic [63:0] m_line [4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_req = 0; m_ack = 0; m_busy = 0; m_burst = 0; m_abandon = 0; m_lock = 0;
            m_got = 0; m_addr = '0;
            for (int i = 0; i < 4; i++) m_line[i] = '0;
        end else if (m_ack) begin
            m_ack = 0; m_busy = 0; m_lock = 1;
        end else if (m_burst) begin
            if (fetch_flush) m_abandon = 1;
            if (mem_rvalid) begin
                m_line[m_got] = mem_rdata;
                m_got++;
                if (m_got == 4) begin
                    m_burst = 0;
                    if (m_abandon) m_busy = 0;
                    else m_ack = 1;
                    m_abandon = 0;
                end
            end
        end else if (m_req) begin
            if (mem_gnt) begin
                m_req = 0; m_burst = 1; m_got = 0; m_abandon = fetch_flush;
            end else if (fetch_flush) begin
                m_req = 0; m_busy = 0;
            end
        end else if (m_lock) begin
            m_lock = 0;
        end else if (ic_miss && !fetch_flush) begin
            m_req = 1; m_busy = 1;
            m_addr = ic_miss_addr & 15'h7FE0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("busy", busy, m_busy);
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_addr);
        chk("ic_miss_ack", ic_miss_ack, m_ack);
        chk("ic_fill_data", ic_fill_data, {m_line[3], m_line[2], m_line[1], m_line[0]});
    endtask

    task automatic beat(input logic [63:0] d);
        mem_rvalid = 1; mem_rdata = d;
        step();
        mem_rvalid = 0;
    endtask

    task automatic idle_in();
        rst = 0; ic_miss = 0; fetch_flush = 0; mem_gnt = 0; mem_rvalid = 0;
        ic_miss_addr = '0; mem_rdata = '0;
    endtask

    initial begin
        logic [3:0] nib;
        idle_in();
        rst = 1;
        step(); step();
        rst = 0;
        chk("reset_busy", busy, 0);
        chk("reset_fill", ic_fill_data, 0);
        chk("reset_addr", mem_addr, 0);

        // Basic best-case fill at 0x1A40.
        ic_miss = 1; ic_miss_addr = 15'h1A40; mem_gnt = 1;
        step();
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 15'h1A40);
        step();
        mem_gnt = 0;
        for (int k = 0; k < 4; k++) begin
            nib = 4'(k);
            beat({16{nib}});
            if (k < 3) chk("early_ack", ic_miss_ack, 0);
        end
        chk("t6_ack", ic_miss_ack, 1);
        chk("t6_fill", ic_fill_data, {64'h3333333333333333, 64'h2222222222222222,
                                      64'h1111111111111111, 64'h0000000000000000});

        // Miss held through ack: re-arm only on the third cycle after ack.
        step();
        chk("lock_ack_off", ic_miss_ack, 0);
        chk("lock1_req", mem_req, 0);
        step();
        chk("lock2_req", mem_req, 0);
        step();
        chk("rearm_req", mem_req, 1);

        // Flush in REQ before grant.
        ic_miss = 0; fetch_flush = 1;
        step();
        chk("flush_req_low", mem_req, 0);
        chk("flush_req_busy", busy, 0);
        fetch_flush = 0;

        // Unaligned address, delayed grant, gapped beats.
        ic_miss = 1; ic_miss_addr = 15'h1A5F;
        step();
        chk("unalign_addr", mem_addr, 15'h1A40);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_req_held", mem_req, 1);
        end
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("gnt_req_drop", mem_req, 0);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g <= k; g++) step();
            beat({$urandom, $urandom});
        end
        chk("stall_ack", ic_miss_ack, 1);
        ic_miss = 0;
        step();
        chk("stall_single_ack", ic_miss_ack, 0);
        step();

        // Flush in DATA after the first beat: drained, no ack.
        ic_miss = 1; ic_miss_addr = 15'(($urandom));
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        beat({$urandom, $urandom});
        ic_miss = 0; fetch_flush = 1;
        step();
        fetch_flush = 0;
        for (int k = 0; k < 3; k++) begin
            chk("drain_busy", busy, 1);
            beat({$urandom, $urandom});
            chk("drain_no_ack", ic_miss_ack, 0);
        end
        chk("drain_idle", busy, 0);

        // Flush and grant together: grant wins, beats drained, no ack.
        ic_miss = 1; ic_miss_addr = 15'h0440;
        step();
        mem_gnt = 1; fetch_flush = 1; ic_miss = 0;
        step();
        mem_gnt = 0; fetch_flush = 0;
        chk("fg_busy", busy, 1);
        for (int k = 0; k < 4; k++) begin
            beat({$urandom, $urandom});
            chk("fg_no_ack", ic_miss_ack, 0);
        end
        chk("fg_idle", busy, 0);

        // Reset mid-burst, then a fresh fill.
        ic_miss = 1; ic_miss_addr = 15'h2BC0;
        step();
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        beat(64'hDEADBEEF00000001);
        beat(64'hDEADBEEF00000002);
        rst = 1;
        step();
        rst = 0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_fill", ic_fill_data, 0);
        ic_miss_addr = 15'h0123; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_rvalid = 0;
        chk("idle_beat_ignored", ic_fill_data, 0);
        chk("fresh_addr", mem_addr, 15'h0120);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        for (int k = 0; k < 4; k++) beat(64'hA000_0000_0000_0000 | 64'(k));
        chk("fresh_ack", ic_miss_ack, 1);
        chk("fresh_fill", ic_fill_data, {64'hA000000000000003, 64'hA000000000000002,
                                         64'hA000000000000001, 64'hA000000000000000});
        ic_miss = 0;
        step(); step();

        // Random traffic.
        idle_in();
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            ic_miss      = $urandom_range(0, 1) == 1;
            fetch_flush  = ($urandom_range(0, 19) == 0);
            mem_gnt      = ($urandom_range(0, 2) == 0);
            mem_rvalid   = ($urandom_range(0, 2) != 0);
            ic_miss_addr = 15'($urandom);
            mem_rdata    = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
